// File: rtl/uu_acmac_rx_fcs_check_pkg.sv
// Shared LMAC RX constants, FSM state type and small helpers for the FCS checker.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
`ifndef UU_LMAC_DEFINES
`define UU_LMAC_DEFINES
`define UU_LMAC_RX_RET_SUCCESS                   3'd0
`define UU_LMAC_RX_RET_DELIMITER_ERROR           3'd1
`define UU_LMAC_RX_RET_LENGTH_ERROR              3'd2
`define UU_LMAC_RX_RET_INCOMPLETE_AMPDU_SUBFRAME 3'd3
`define UU_LMAC_RX_RET_END_OF_AMPDU              3'd4
`define UU_LMAC_CRC32_POLY                       32'hEDB88320
`define UU_LMAC_CRC32_RESIDUE                    32'hDEBB20E3
`define UU_LMAC_MIN_MPDU_LEN                     5
`endif

package uu_acmac_rx_fcs_check_pkg;

  localparam int WIDTH_BYTE      = 8;
  localparam int WIDTH_HALF_WORD = 16;
  localparam int WIDTH_WORD      = 32;

  localparam logic [WIDTH_WORD-1:0]      CRC32_POLY     = `UU_LMAC_CRC32_POLY;
  localparam logic [WIDTH_WORD-1:0]      CRC32_RESIDUE  = `UU_LMAC_CRC32_RESIDUE;
  localparam logic [WIDTH_WORD-1:0]      CRC32_INIT     = 32'hFFFF_FFFF;
  localparam logic [WIDTH_HALF_WORD-1:0] MIN_MPDU_LEN   = 16'(`UU_LMAC_MIN_MPDU_LEN);
  localparam logic [2:0]                 RET_INCOMPLETE = `UU_LMAC_RX_RET_INCOMPLETE_AMPDU_SUBFRAME;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2
  } fcs_state_e;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [WIDTH_HALF_WORD-1:0] sat_inc(input logic [WIDTH_HALF_WORD-1:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uu_acmac_crc32_8in.sv
// Byte-wide reflected CRC-32 next-state (poly EDB88320, LSB first), shared with TX FCS gen.
// Latency: purely combinational.
// Backpressure: none; caller decides when to commit crc_out.
module uu_acmac_crc32_8in
  import uu_acmac_rx_fcs_check_pkg::*;
(
  input  logic [WIDTH_WORD-1:0] crc_in,
  input  logic [WIDTH_BYTE-1:0] data,
  output logic [WIDTH_WORD-1:0] crc_out
);

  logic [WIDTH_WORD-1:0] c;

  // Fold the byte into the low bits, then shift out eight bits LSB first.
  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/uu_acmac_rx_fcs_check.sv
// Per-subframe FCS checker: bounds each MPDU by its length, forwards bytes, runs CRC-32 residue check.
// Latency: forwarded byte, done/fcs_ok/counters one cycle after the input byte; abort one cycle after detection.
// Backpressure: none; bytes are consumed every strobe, trailing/pad bytes after the MPDU are discarded.
module uu_acmac_rx_fcs_check
  import uu_acmac_rx_fcs_check_pkg::*;
(
  input  logic                       fcs_clk,
  input  logic                       rst_n,
  input  logic                       fcs_enable,
  input  logic [WIDTH_BYTE-1:0]      fcs_in_data,
  input  logic                       fcs_in_data_valid,
  input  logic                       fcs_in_mpdu_valid,
  input  logic [WIDTH_HALF_WORD-1:0] fcs_in_subframe_length,
  input  logic [2:0]                 fcs_in_return_value,
  output logic [WIDTH_BYTE-1:0]      fcs_out_data,
  output logic                       fcs_out_data_valid,
  output logic                       fcs_out_first,
  output logic                       fcs_out_last,
  output logic                       fcs_out_done,
  output logic                       fcs_out_fcs_ok,
  output logic                       fcs_out_abort,
  output logic [WIDTH_HALF_WORD-1:0] fcs_out_mpdu_length,
  output logic [WIDTH_HALF_WORD-1:0] fcs_out_ok_count,
  output logic [WIDTH_HALF_WORD-1:0] fcs_out_err_count
);

  fcs_state_e                 state_q, state_d;
  logic                       mpdu_vld_q;
  logic [WIDTH_HALF_WORD-1:0] len_q, len_d;
  logic [WIDTH_WORD-1:0]      crc_q, crc_d;
  logic [WIDTH_HALF_WORD-1:0] cnt_q, cnt_d;
  logic [WIDTH_BYTE-1:0]      out_data_q, out_data_d;
  logic                       out_vld_q, out_vld_d;
  logic                       first_q, first_d;
  logic                       last_q, last_d;
  logic                       done_q, done_d;
  logic                       abort_q, abort_d;
  logic                       fcs_ok_q, fcs_ok_d;
  logic [WIDTH_HALF_WORD-1:0] ok_cnt_q, ok_cnt_d;
  logic [WIDTH_HALF_WORD-1:0] err_cnt_q, err_cnt_d;

  logic                       rise;
  logic                       trunc;
  logic                       accept;
  logic                       in_idle;
  logic [WIDTH_WORD-1:0]      crc_cur, crc_next;
  logic [WIDTH_HALF_WORD-1:0] cnt_cur, len_cur;

  // The first payload byte arrives together with the mpdu_valid rise, so in IDLE
  // the byte is processed against freshly initialised CRC/count/length values.
  assign rise    = fcs_in_mpdu_valid & ~mpdu_vld_q;
  assign trunc   = ~fcs_in_mpdu_valid | (fcs_in_return_value == RET_INCOMPLETE);
  assign in_idle = (state_q == ST_IDLE);
  assign crc_cur = in_idle ? CRC32_INIT : crc_q;
  assign cnt_cur = in_idle ? '0 : cnt_q;
  assign len_cur = in_idle ? fcs_in_subframe_length : len_q;

  uu_acmac_crc32_8in u_crc (
    .crc_in  (crc_cur),
    .data    (fcs_in_data),
    .crc_out (crc_next)
  );

  // Next-state, forwarding and statistics; disable overrides everything but the counters.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    out_data_d = '0;
    out_vld_d  = 1'b0;
    first_d    = 1'b0;
    last_d     = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    fcs_ok_d   = fcs_ok_q;
    ok_cnt_d   = ok_cnt_q;
    err_cnt_d  = err_cnt_q;
    accept     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          len_d    = fcs_in_subframe_length;
          crc_d    = CRC32_INIT;
          cnt_d    = '0;
          fcs_ok_d = 1'b0;
          if (fcs_in_subframe_length < MIN_MPDU_LEN) begin
            abort_d   = 1'b1;
            err_cnt_d = sat_inc(err_cnt_q);
            state_d   = ST_DRAIN;
          end else begin
            state_d = ST_RECV;
            accept  = 1'b1;
          end
        end
      end
      ST_RECV:  accept = 1'b1;
      ST_DRAIN: if (!fcs_in_mpdu_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (accept) begin
      if (trunc) begin
        // Truncation wins over a byte arriving in the same cycle.
        abort_d   = 1'b1;
        err_cnt_d = sat_inc(err_cnt_q);
        state_d   = ST_IDLE;
      end else if (fcs_in_data_valid) begin
        crc_d      = crc_next;
        cnt_d      = cnt_cur + 16'd1;
        out_data_d = fcs_in_data;
        out_vld_d  = 1'b1;
        first_d    = (cnt_cur == '0);
        if (({1'b0, cnt_cur} + 17'd1) == {1'b0, len_cur}) begin
          last_d   = 1'b1;
          done_d   = 1'b1;
          fcs_ok_d = (crc_next == CRC32_RESIDUE);
          state_d  = ST_DRAIN;
          if (crc_next == CRC32_RESIDUE) ok_cnt_d  = sat_inc(ok_cnt_q);
          else                           err_cnt_d = sat_inc(err_cnt_q);
        end
      end
    end

    if (!fcs_enable) begin
      state_d    = ST_IDLE;
      len_d      = '0;
      crc_d      = CRC32_INIT;
      cnt_d      = '0;
      out_data_d = '0;
      out_vld_d  = 1'b0;
      first_d    = 1'b0;
      last_d     = 1'b0;
      done_d     = 1'b0;
      abort_d    = 1'b0;
      fcs_ok_d   = 1'b0;
      ok_cnt_d   = ok_cnt_q;
      err_cnt_d  = err_cnt_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge fcs_clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mpdu_vld_q <= 1'b0;
      len_q      <= '0;
      crc_q      <= CRC32_INIT;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      fcs_ok_q   <= 1'b0;
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      // Keeps tracking while disabled so re-enable mid-MPDU does not fake a rise.
      mpdu_vld_q <= fcs_in_mpdu_valid;
      len_q      <= len_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      first_q    <= first_d;
      last_q     <= last_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      fcs_ok_q   <= fcs_ok_d;
      ok_cnt_q   <= ok_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign fcs_out_data        = out_data_q;
  assign fcs_out_data_valid  = out_vld_q;
  assign fcs_out_first       = first_q;
  assign fcs_out_last        = last_q;
  assign fcs_out_done        = done_q;
  assign fcs_out_fcs_ok      = fcs_ok_q;
  assign fcs_out_abort       = abort_q;
  assign fcs_out_mpdu_length = len_q;
  assign fcs_out_ok_count    = ok_cnt_q;
  assign fcs_out_err_count   = err_cnt_q;

endmodule

// File: tb/tb_uu_acmac_rx_fcs_check.sv
// Directed bench for the RX FCS checker: good/bad FCS, truncation, short length, back-to-back, enable drop.
// Latency: outputs sampled 1 time unit after the clock edge following each driven byte.
// Backpressure: none; stimulus is one byte per cycle.
module tb_uu_acmac_rx_fcs_check;
  import uu_acmac_rx_fcs_check_pkg::*;

  logic        fcs_clk = 1'b0;
  logic        rst_n;
  logic        fcs_enable;
  logic [7:0]  fcs_in_data;
  logic        fcs_in_data_valid;
  logic        fcs_in_mpdu_valid;
  logic [15:0] fcs_in_subframe_length;
  logic [2:0]  fcs_in_return_value;
  logic [7:0]  fcs_out_data;
  logic        fcs_out_data_valid;
  logic        fcs_out_first;
  logic        fcs_out_last;
  logic        fcs_out_done;
  logic        fcs_out_fcs_ok;
  logic        fcs_out_abort;
  logic [15:0] fcs_out_mpdu_length;
  logic [15:0] fcs_out_ok_count;
  logic [15:0] fcs_out_err_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] fr [0:127];

  int         mon_fwd = 0;
  int         mon_first_idx = -1;
  int         mon_last_idx = -1;
  int         mon_done = 0;
  int         mon_abort = 0;
  logic [7:0] mon_dat [0:511];

  int f0, d0, a0;

  always #5 fcs_clk = ~fcs_clk;

  uu_acmac_rx_fcs_check dut (
    .fcs_clk                (fcs_clk),
    .rst_n                  (rst_n),
    .fcs_enable             (fcs_enable),
    .fcs_in_data            (fcs_in_data),
    .fcs_in_data_valid      (fcs_in_data_valid),
    .fcs_in_mpdu_valid      (fcs_in_mpdu_valid),
    .fcs_in_subframe_length (fcs_in_subframe_length),
    .fcs_in_return_value    (fcs_in_return_value),
    .fcs_out_data           (fcs_out_data),
    .fcs_out_data_valid     (fcs_out_data_valid),
    .fcs_out_first          (fcs_out_first),
    .fcs_out_last           (fcs_out_last),
    .fcs_out_done           (fcs_out_done),
    .fcs_out_fcs_ok         (fcs_out_fcs_ok),
    .fcs_out_abort          (fcs_out_abort),
    .fcs_out_mpdu_length    (fcs_out_mpdu_length),
    .fcs_out_ok_count       (fcs_out_ok_count),
    .fcs_out_err_count      (fcs_out_err_count)
  );

  // Record forwarded bytes and pulses on the falling edge.
  always @(negedge fcs_clk) begin
    if (fcs_out_data_valid) begin
      if (mon_fwd < 512) mon_dat[mon_fwd] <= fcs_out_data;
      if (fcs_out_first) mon_first_idx <= mon_fwd;
      if (fcs_out_last) mon_last_idx <= mon_fwd;
      mon_fwd <= mon_fwd + 1;
    end
    if (fcs_out_done) mon_done <= mon_done + 1;
    if (fcs_out_abort) mon_abort <= mon_abort + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b, input logic dv, input logic mv);
    fcs_in_data       = b;
    fcs_in_data_valid = dv;
    fcs_in_mpdu_valid = mv;
    @(posedge fcs_clk);
    #1;
  endtask

  task automatic load_good();
    for (int i = 0; i < 9; i++) fr[i] = 8'h31 + 8'(i);
    fr[9]  = 8'h26;
    fr[10] = 8'h39;
    fr[11] = 8'hF4;
    fr[12] = 8'hCB;
  endtask

  task automatic send(input logic [15:0] len, input int nb);
    fcs_in_subframe_length = len;
    for (int i = 0; i < nb; i++) put(fr[i], 1'b1, 1'b1);
  endtask

  task automatic snap();
    put(8'h00, 1'b0, 1'b0);
    f0 = mon_fwd;
    d0 = mon_done;
    a0 = mon_abort;
  endtask

  initial begin
    rst_n = 1'b0;
    fcs_enable = 1'b1;
    fcs_in_return_value = 3'd0;
    fcs_in_subframe_length = 16'd13;
    put(8'hAA, 1'b1, 1'b1);
    put(8'h55, 1'b1, 1'b0);
    put(8'h00, 1'b0, 1'b0);
    chk("rst_vld", 32'(fcs_out_data_valid), 32'd0);
    chk("rst_len", 32'(fcs_out_mpdu_length), 32'd0);
    chk("rst_cnts", {fcs_out_ok_count, fcs_out_err_count}, 32'd0);
    chk("rst_pulses", {28'd0, fcs_out_done, fcs_out_abort, fcs_out_fcs_ok, fcs_out_first}, 32'd0);
    rst_n = 1'b1;
    put(8'h00, 1'b0, 1'b0);

    // Good FCS
    load_good();
    snap();
    send(16'd13, 13);
    chk("good_done_t", 32'(fcs_out_done), 32'd1);
    chk("good_last_t", 32'(fcs_out_last), 32'd1);
    chk("good_ok", 32'(fcs_out_fcs_ok), 32'd1);
    chk("good_okcnt", 32'(fcs_out_ok_count), 32'd1);
    chk("good_len", 32'(fcs_out_mpdu_length), 32'd13);
    put(8'h00, 1'b0, 1'b0);
    put(8'h00, 1'b0, 1'b0);
    chk("good_fwd", 32'(mon_fwd - f0), 32'd13);
    chk("good_first_idx", 32'(mon_first_idx - f0), 32'd0);
    chk("good_last_idx", 32'(mon_last_idx - f0), 32'd12);
    for (int i = 0; i < 13; i++) chk($sformatf("good_dat%0d", i), 32'(mon_dat[f0 + i]), 32'(fr[i]));
    chk("good_okhold", 32'(fcs_out_fcs_ok), 32'd1);

    // Bad FCS
    fr[4] = 8'h00;
    snap();
    send(16'd13, 13);
    chk("bad_done", 32'(fcs_out_done), 32'd1);
    chk("bad_ok", 32'(fcs_out_fcs_ok), 32'd0);
    chk("bad_errcnt", 32'(fcs_out_err_count), 32'd1);
    chk("bad_okcnt", 32'(fcs_out_ok_count), 32'd1);
    put(8'h00, 1'b0, 1'b0);
    put(8'h00, 1'b0, 1'b0);
    chk("bad_noabort", 32'(mon_abort - a0), 32'd0);

    // Truncation after 40 of 100 bytes
    for (int i = 0; i < 40; i++) fr[i] = 8'(i + 16);
    snap();
    send(16'd100, 40);
    chk("tr_no_abort_yet", 32'(fcs_out_abort), 32'd0);
    put(8'h00, 1'b0, 1'b0);
    chk("tr_abort", 32'(fcs_out_abort), 32'd1);
    chk("tr_errcnt", 32'(fcs_out_err_count), 32'd2);
    put(8'h00, 1'b0, 1'b0);
    chk("tr_abort_pulse", 32'(fcs_out_abort), 32'd0);
    put(8'h00, 1'b0, 1'b0);
    chk("tr_fwd", 32'(mon_fwd - f0), 32'd40);
    chk("tr_nodone", 32'(mon_done - d0), 32'd0);

    // Short length, then a good frame
    snap();
    fcs_in_subframe_length = 16'd3;
    put(8'h11, 1'b1, 1'b1);
    chk("sh_abort", 32'(fcs_out_abort), 32'd1);
    chk("sh_len", 32'(fcs_out_mpdu_length), 32'd3);
    put(8'h22, 1'b1, 1'b1);
    put(8'h33, 1'b1, 1'b1);
    chk("sh_errcnt", 32'(fcs_out_err_count), 32'd3);
    put(8'h00, 1'b0, 1'b0);
    put(8'h00, 1'b0, 1'b0);
    chk("sh_fwd", 32'(mon_fwd - f0), 32'd0);
    load_good();
    send(16'd13, 13);
    chk("sh_next_ok", 32'(fcs_out_fcs_ok), 32'd1);
    chk("sh_next_okcnt", 32'(fcs_out_ok_count), 32'd2);

    // Back-to-back with 2 pad bytes
    snap();
    send(16'd13, 13);
    put(8'hAA, 1'b1, 1'b0);
    put(8'hAB, 1'b1, 1'b0);
    send(16'd13, 13);
    put(8'h00, 1'b0, 1'b0);
    put(8'h00, 1'b0, 1'b0);
    chk("b2b_done", 32'(mon_done - d0), 32'd2);
    chk("b2b_okcnt", 32'(fcs_out_ok_count), 32'd4);
    chk("b2b_fwd", 32'(mon_fwd - f0), 32'd26);
    chk("b2b_second_first", 32'(mon_dat[f0 + 13]), 32'h31);

    // Enable low during byte 6 of 13
    snap();
    send(16'd13, 5);
    fcs_enable = 1'b0;
    put(fr[5], 1'b1, 1'b1);
    chk("en_vld", 32'(fcs_out_data_valid), 32'd0);
    chk("en_data", 32'(fcs_out_data), 32'd0);
    chk("en_len", 32'(fcs_out_mpdu_length), 32'd0);
    chk("en_cnts", {fcs_out_ok_count, fcs_out_err_count}, {16'd4, 16'd3});
    put(fr[6], 1'b1, 1'b1);
    put(8'h00, 1'b0, 1'b0);
    chk("en_nopulse", 32'((mon_done - d0) + (mon_abort - a0)), 32'd0);
    fcs_enable = 1'b1;
    put(8'h00, 1'b0, 1'b0);
    send(16'd13, 13);
    chk("en_after_ok", 32'(fcs_out_fcs_ok), 32'd1);
    chk("en_after_okcnt", 32'(fcs_out_ok_count), 32'd5);

    // Incomplete-subframe return value mid-MPDU; the coinciding byte is dropped
    snap();
    send(16'd13, 3);
    fcs_in_return_value = RET_INCOMPLETE;
    put(fr[3], 1'b1, 1'b1);
    fcs_in_return_value = 3'd0;
    chk("inc_abort", 32'(fcs_out_abort), 32'd1);
    chk("inc_errcnt", 32'(fcs_out_err_count), 32'd4);
    put(8'h00, 1'b0, 1'b0);
    put(8'h00, 1'b0, 1'b0);
    chk("inc_fwd", 32'(mon_fwd - f0), 32'd3);
    chk("inc_nodone", 32'(mon_done - d0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
